// File: rtl/toggle_ctrl.sv
`timescale 1ns/1ps
// Programmable toggle-enable generator driving the t input of a T flip-flop stage.
// Optional pause input is enabled by defining TOGGLE_CTRL_PAUSE_EN.
module toggle_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
`ifdef TOGGLE_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] burst,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] div_r, div_s;
  logic [CNT_W-1:0] per_r, per_s;
  logic [CNT_W-1:0] burst_r, burst_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             t_r, t_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pause_s;

`ifdef TOGGLE_CTRL_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; per_r is always >= 1 so per_r-1 cannot underflow.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    per_s   = per_r;
    burst_s = burst_r;
    cnt_s   = cnt_r;
    t_s     = t_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        t_s = 1'b0;
        if (start && !stop) begin
          state_s = RUN;
          per_s   = (period == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : period;
          burst_s = burst;
          div_s   = {CNT_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_s = IDLE;
          t_s     = 1'b0;
          busy_s  = 1'b0;
        end else if (pause_s) begin
          t_s = 1'b0;
        end else if (div_r == per_r - {{(CNT_W-1){1'b0}}, 1'b1}) begin
          div_s = {CNT_W{1'b0}};
          t_s   = 1'b1;
          cnt_s = cnt_inc_s;
          if ((burst_r != {CNT_W{1'b0}}) && (cnt_inc_s == burst_r)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          div_s = div_r + {{(CNT_W-1){1'b0}}, 1'b1};
          t_s   = 1'b0;
        end
      end
      DONE: begin
        state_s = IDLE;
        t_s     = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
      default: begin
        state_s = IDLE;
        t_s     = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      div_r   <= {CNT_W{1'b0}};
      per_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
      burst_r <= {CNT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      t_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      per_r   <= per_s;
      burst_r <= burst_s;
      cnt_r   <= cnt_s;
      t_r     <= t_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign t         = t_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pulse_cnt = cnt_r;

endmodule

// File: tb/tb_toggle_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for toggle_ctrl: cycle model based on elapsed time plus directed literal checks.
module tb_toggle_ctrl;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic [CNT_W-1:0] period = 8'd0;
  logic [CNT_W-1:0] burst = 8'd0;
  logic             t, busy, done;
  logic [CNT_W-1:0] pulse_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a running sequence emits a pulse whenever the elapsed (unpaused) cycle count is a multiple of P.
  bit m_run, m_t, m_busy, m_done, m_done_pend;
  int m_el, m_p, m_b, m_n;

  toggle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
`ifdef TOGGLE_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .period(period),
    .burst(burst),
    .t(t),
    .busy(busy),
    .done(done),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit paused;
`ifdef TOGGLE_CTRL_PAUSE_EN
    paused = pause;
`else
    paused = 1'b0;
`endif
    if (reset) begin
      m_run = 0; m_t = 0; m_busy = 0; m_done = 0; m_done_pend = 0;
      m_el = 0; m_p = 1; m_b = 0; m_n = 0;
    end else if (m_done_pend) begin
      m_done_pend = 0; m_t = 0; m_busy = 0; m_done = 1; m_run = 0;
    end else if (!m_run) begin
      m_t = 0; m_done = 0;
      if (start && !stop) begin
        m_run = 1; m_busy = 1; m_el = 0; m_n = 0;
        m_p = (period == 0) ? 1 : int'(period);
        m_b = int'(burst);
      end
    end else begin
      m_done = 0;
      if (stop) begin
        m_run = 0; m_t = 0; m_busy = 0;
      end else if (paused) begin
        m_t = 0;
      end else begin
        m_el++;
        if (m_el % m_p == 0) begin
          m_t = 1;
          m_n = (m_n + 1) % 256;
          if (m_b != 0 && m_n == m_b) begin
            m_done_pend = 1; m_run = 0;
          end
        end else begin
          m_t = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_t", {31'd0, t}, {31'd0, m_t});
      check("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_pulse_cnt", {24'd0, pulse_cnt}, m_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic go(input logic [7:0] p, input logic [7:0] b);
    period = p; burst = b; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("reset_t", {31'd0, t}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cnt", {24'd0, pulse_cnt}, 32'd0);

    // Finite burst: period 3, burst 4
    go(8'd3, 8'd4);
    cyc(2);  check("burst_e2_t", {31'd0, t}, 32'd0);
    cyc(1);  check("burst_e3_t", {31'd0, t}, 32'd1);
             check("burst_e3_cnt", {24'd0, pulse_cnt}, 32'd1);
    cyc(9);  check("burst_e12_t", {31'd0, t}, 32'd1);
             check("burst_e12_cnt", {24'd0, pulse_cnt}, 32'd4);
             check("burst_e12_busy", {31'd0, busy}, 32'd1);
    cyc(1);  check("burst_e13_done", {31'd0, done}, 32'd1);
             check("burst_e13_busy", {31'd0, busy}, 32'd0);
             check("burst_e13_t", {31'd0, t}, 32'd0);
    cyc(1);  check("burst_e14_done", {31'd0, done}, 32'd0);

    // Start/stop collision, then mid-run period change and stray start
    start = 1'b1; stop = 1'b1; period = 8'd3;
    cyc(1);  check("collide_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; stop = 1'b0;
    go(8'd3, 8'd0);
    period = 8'd5;
    cyc(2);  check("chg_e2_t", {31'd0, t}, 32'd0);
    cyc(1);  check("chg_e3_t", {31'd0, t}, 32'd1);
    start = 1'b1;
    cyc(1);  start = 1'b0;
    cyc(2);  check("chg_e6_t", {31'd0, t}, 32'd1);
             check("chg_e6_cnt", {24'd0, pulse_cnt}, 32'd2);
    stop = 1'b1;
    cyc(1);  stop = 1'b0;
             check("chg_stop_busy", {31'd0, busy}, 32'd0);

    // Abort mid-burst then restart
    go(8'd4, 8'd10);
    cyc(8);  check("abort_e8_cnt", {24'd0, pulse_cnt}, 32'd2);
    stop = 1'b1;
    cyc(1);  stop = 1'b0;
             check("abort_busy", {31'd0, busy}, 32'd0);
             check("abort_cnt_hold", {24'd0, pulse_cnt}, 32'd2);
    cyc(3);  check("abort_no_done", {31'd0, done}, 32'd0);
    go(8'd4, 8'd10);
             check("restart_cnt", {24'd0, pulse_cnt}, 32'd0);
             check("restart_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    cyc(1);  stop = 1'b0;

    // Continuous mode with period 0, counter wrap
    go(8'd0, 8'd0);
    cyc(1);   check("cont_e1_t", {31'd0, t}, 32'd1);
              check("cont_e1_cnt", {24'd0, pulse_cnt}, 32'd1);
    cyc(255); check("cont_wrap_cnt", {24'd0, pulse_cnt}, 32'd0);
              check("cont_wrap_t", {31'd0, t}, 32'd1);
    cyc(2);   check("cont_cnt2", {24'd0, pulse_cnt}, 32'd2);
    stop = 1'b1;
    cyc(1);   stop = 1'b0;
              check("cont_stop_t", {31'd0, t}, 32'd0);
              check("cont_stop_busy", {31'd0, busy}, 32'd0);
    cyc(2);   check("cont_no_done", {31'd0, done}, 32'd0);

`ifdef TOGGLE_CTRL_PAUSE_EN
    // Pause between pulses: period 4, pause held 6 cycles after E0+5
    go(8'd4, 8'd0);
    cyc(4);  check("pause_e4_t", {31'd0, t}, 32'd1);
    cyc(1);  pause = 1'b1;
    cyc(6);  check("pause_hold_t", {31'd0, t}, 32'd0);
             check("pause_hold_busy", {31'd0, busy}, 32'd1);
             check("pause_hold_cnt", {24'd0, pulse_cnt}, 32'd1);
    pause = 1'b0;
    cyc(2);  check("pause_resume_t0", {31'd0, t}, 32'd0);
    cyc(1);  check("pause_resume_t1", {31'd0, t}, 32'd1);
             check("pause_resume_cnt", {24'd0, pulse_cnt}, 32'd2);
    stop = 1'b1;
    cyc(1);  stop = 1'b0;
`endif

    // Reset mid-run drops outputs asynchronously, no done afterwards
    go(8'd2, 8'd0);
    cyc(6);  check("rst_pre_t", {31'd0, t}, 32'd1);
             check("rst_pre_cnt", {24'd0, pulse_cnt}, 32'd3);
    reset = 1'b1;
    #1;
    check("rst_async_t", {31'd0, t}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_cnt", {24'd0, pulse_cnt}, 32'd0);
    cyc(2);  reset = 1'b0;
    cyc(3);  check("rst_no_done", {31'd0, done}, 32'd0);
             check("rst_idle_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
